// File: rtl/code_decoder_if.sv
// -----------------------------------------------------------------------------
// code_decoder_if
// Request/response bundle between a requester and the code decoder.
//   start : request pulse, sampled by the decoder only while idle
//   mode  : 00 Gray, 01 excess-3, 10 pass-through, 11 reserved
//   din   : coded word, captured together with start
//   dout  : decoded binary word, held until the next completion
//   stop  : one-cycle completion pulse
//   busy  : conversion in progress (CONV or DONE)
//   err   : error flag of the last completed conversion
// The master modport belongs to the requester and the slave modport to the decoder.
// -----------------------------------------------------------------------------
interface code_decoder_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [1:0]       mode;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             stop;
   logic             busy;
   logic             err;

   modport master (
      output start, mode, din,
      input  dout, stop, busy, err
   );

   modport slave (
      input  start, mode, din,
      output dout, stop, busy, err
   );
endinterface

// File: rtl/code_decoder.sv
// -----------------------------------------------------------------------------
// code_decoder
// Recovers a binary value from a Gray, excess-3 or plain binary code word.
// The decoder uses a start/stop handshake. Gray words are decoded one bit per
// clock, starting at the MSB. The other modes finish in a single CONV cycle.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset; aborts a running conversion
//   bus   : code_decoder_if slave modport (start/mode/din in,
//           dout/stop/busy/err out, all outputs registered)
// -----------------------------------------------------------------------------
module code_decoder #(
   parameter int WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   code_decoder_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CONV = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] cin_r;
   logic [1:0]       cmode_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] acc_r;

   logic [WIDTH-1:0] acc_next;
   logic [WIDTH:0]   acc_ext;
   logic             e_next;
   logic             last_step;

   // The excess-3 digit range is 3..12. Values outside this range are not
   // valid BCD digits. The range check assumes WIDTH = 4.
   function automatic logic xs3_invalid(input logic [WIDTH-1:0] v);
      xs3_invalid = (v < WIDTH'(3)) || (v > WIDTH'(12));
   endfunction

   // Append a zero above the accumulator so that the MSB step is simply
   // 0 ^ cin[MSB]. The Gray recurrence then needs no special case.
   assign acc_ext = {1'b0, acc_r};

   // Compute the next accumulator value, the error flag and the last-step
   // flag for the current CONV cycle.
   always_comb begin
      acc_next  = acc_r;
      e_next    = 1'b0;
      last_step = 1'b1;
      case (cmode_r)
         2'b00: begin
            // Resolve only bit cnt_r in this cycle: acc[i] = acc[i+1] ^ cin[i].
            for (int i = 0; i < WIDTH; i++) begin
               if (int'(cnt_r) == i) begin
                  acc_next[i] = acc_ext[i+1] ^ cin_r[i];
               end else begin
                  acc_next[i] = acc_r[i];
               end
            end
            last_step = (cnt_r == {CW{1'b0}});
         end
         2'b01: begin
            // An out-of-range word still returns the raw difference on dout.
            acc_next = cin_r - WIDTH'(3);
            e_next   = xs3_invalid(cin_r);
         end
         2'b10: begin
            acc_next = cin_r;
            e_next   = 1'b0;
         end
         default: begin
            acc_next = {WIDTH{1'b0}};
            e_next   = 1'b1;
         end
      endcase
   end

   // Control FSM, capture registers, accumulator and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cin_r    <= {WIDTH{1'b0}};
         cmode_r  <= 2'b00;
         cnt_r    <= {CW{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
         bus.dout <= {WIDTH{1'b0}};
         bus.stop <= 1'b0;
         bus.busy <= 1'b0;
         bus.err  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               bus.stop <= 1'b0;
               if (bus.start) begin
                  cin_r    <= bus.din;
                  cmode_r  <= bus.mode;
                  cnt_r    <= (bus.mode == 2'b00) ? CW'(WIDTH - 1) : {CW{1'b0}};
                  acc_r    <= {WIDTH{1'b0}};
                  bus.busy <= 1'b1;
                  state_r  <= CONV;
               end else begin
                  bus.busy <= 1'b0;
                  state_r  <= IDLE;
               end
            end
            CONV: begin
               acc_r <= acc_next;
               // On the final step, publish the result directly from acc_next.
               // This sets dout on the same edge that enters DONE.
               if (last_step) begin
                  bus.dout <= acc_next;
                  bus.err  <= e_next;
                  bus.stop <= 1'b1;
                  state_r  <= DONE;
               end else begin
                  cnt_r    <= cnt_r - CW'(1);
                  state_r  <= CONV;
               end
            end
            DONE: begin
               bus.stop <= 1'b0;
               bus.busy <= 1'b0;
               state_r  <= IDLE;
            end
            default: begin
               bus.stop <= 1'b0;
               bus.busy <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

endmodule
